obi_sbr_mem: RTL and testbench
==============================

OBI_SBR_MEM -- requirements
Module: obi_sbr_mem

Interface
REQ-001 SHALL take parameter AddrWidth, default 32: request address width in bits.
REQ-002 SHALL take parameter DataWidth, default 32: data width in bits, a power of two and at least 8.
REQ-003 SHALL take parameter IdWidth, default 8: width of the transaction ID.
REQ-004 SHALL take parameter NumWords, default 1024: memory depth in words, a power of two.
REQ-005 SHALL take parameter MaxTrans, default 4: maximum outstanding responses, which is also the response FIFO depth (at least 1).
REQ-006 SHALL have port clk_i, input, 1 bit: single clock, all state on the rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port req_i, input, 1 bit: A-channel request valid.
REQ-009 SHALL have port gnt_o, output, 1 bit: A-channel grant.
REQ-010 SHALL have port addr_i, input, AddrWidth bits: byte address.
REQ-011 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-012 SHALL have port be_i, input, DataWidth/8 bits: byte enables.
REQ-013 SHALL have port wdata_i, input, DataWidth bits: write data.
REQ-014 SHALL have port aid_i, input, IdWidth bits: request ID.
REQ-015 SHALL have port rvalid_o, output, 1 bit: R-channel valid.
REQ-016 SHALL have port rready_i, input, 1 bit: R-channel ready.
REQ-017 SHALL have port rdata_o, output, DataWidth bits: read data.
REQ-018 SHALL have port rid_o, output, IdWidth bits: response ID, echoing aid_i.
REQ-019 SHALL have port err_o, output, 1 bit: response error flag.

Function
REQ-020 A-handshake SHALL occur on a rising edge where req_i and gnt_o are both 1; req_i, addr_i, we_i, be_i, wdata_i and aid_i SHALL be stable while req_i=1 and gnt_o=0.
REQ-021 gnt_o SHALL be 1 exactly when the registered outstanding count is less than MaxTrans; it SHALL depend on neither req_i nor rready_i (no combinational path).
REQ-022 Word index SHALL be addr_i[$clog2(DataWidth/8) +: $clog2(NumWords)]; low byte-offset bits SHALL be ignored.
REQ-023 On a write handshake, only bytes with be_i set SHALL be updated at that edge; the response SHALL carry rdata_o=0.
REQ-024 On a read handshake, the word value SHALL be sampled at that edge, including any write committed at an earlier edge; rdata_o SHALL carry that value.
REQ-025 Each handshake SHALL push {rdata, aid, err} into the response FIFO at the same edge; rvalid_o SHALL rise in the following cycle at the earliest (1-cycle latency).
REQ-026 Responses SHALL be returned strictly in handshake order.
REQ-027 rvalid_o/rdata_o/rid_o/err_o SHALL hold stable until rvalid_o and rready_i are both 1; the FIFO SHALL pop on that edge.
REQ-028 The outstanding count SHALL be incremented on a handshake, decremented on a pop, and unchanged when both occur in the same cycle.
REQ-029 When the count equals MaxTrans, gnt_o SHALL be 0 in that cycle even if a pop occurs; grant resumes in the cycle after the pop.
REQ-030 The count SHALL never exceed MaxTrans nor underflow; a pop with an empty FIFO SHALL be impossible because rvalid_o=0 whenever the FIFO is empty.

Reset
REQ-031 While rst_i=1: gnt_o=0, rvalid_o=0, rdata_o=0, rid_o=0, err_o=0, FIFO empty, count=0.
REQ-032 Assertion of rst_i mid-operation SHALL discard all pending responses immediately.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 gnt_o SHALL be 1 in the first cycle after rst_i deasserts.

Configuration
REQ-035 Macro OBI_SBR_MEM_RANGE_ERR_EN, when defined: a request with addr_i >= NumWords*DataWidth/8 SHALL respond err_o=1 and rdata_o=0, and SHALL not modify memory.
REQ-036 Macro OBI_SBR_MEM_RANGE_ERR_EN, when undefined: the address SHALL wrap modulo the memory size per REQ-022, and err_o SHALL be tied to 0.

Verification (defaults)
REQ-037 Write 0x1100, be=0xF, data 0xDEADBEEF, id 2 -> response rid=2, err=0, rdata=0; then read 0x1100, id 3 -> rdata=0xDEADBEEF, rid=3, rvalid rises 1 cycle after the handshake.
REQ-038 Write 0x20 = 0x11223344, then write 0x20, be=0x2, data 0xAABBCCDD -> a read of 0x20 returns 0x1122CC44.
REQ-039 With rready_i held 0, issue 6 back-to-back reads -> exactly 4 handshakes occur, then gnt_o=0; after 1 pop, gnt_o returns to 1 in the next cycle; all 6 responses arrive in order with correct IDs.
REQ-040 With rready_i held 1, continuous requests -> one handshake and one response per cycle, count steady at 1.
REQ-041 Read 0x1000 (first word past the end): with the macro defined -> err=1, rdata=0; without the macro -> returns word 0 contents, err=0.
REQ-042 Assert rst_i with 3 responses pending -> rvalid_o=0 immediately; after release, gnt_o=1 and no stale response appears.

Source files
------------

// File: rtl/obi_sbr_mem.sv
// OBI subordinate memory: single-cycle word array behind an in-order response FIFO.
// Define OBI_SBR_MEM_RANGE_ERR_EN to flag out-of-range addresses instead of wrapping them.
module obi_sbr_mem #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 8,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned MaxTrans  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [IdWidth-1:0]     rid_o,
    output logic                   err_o
);

    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam int unsigned PtrW     = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW     = $clog2(MaxTrans + 1);

    logic [DataWidth-1:0] mem_q [NumWords];

    logic [DataWidth-1:0] fifo_data_q [MaxTrans];
    logic [IdWidth-1:0]   fifo_id_q   [MaxTrans];
    logic                 fifo_err_q  [MaxTrans];

    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;

    logic [IdxW-1:0]      word_idx;
    logic                 addr_err;
    logic                 hs;
    logic                 pop;
    logic                 mem_we;
    logic [DataWidth-1:0] push_data;
    logic                 unused_addr;

    assign word_idx    = addr_i[OffW +: IdxW];
    assign unused_addr = ^addr_i;

`ifdef OBI_SBR_MEM_RANGE_ERR_EN
    assign addr_err = |(addr_i >> (OffW + IdxW));
`else
    assign addr_err = 1'b0;
`endif

    // Grant comes from registered state only, so req_i/rready_i never reach gnt_o.
    assign gnt_o    = !rst_i && (count_q < CntW'(MaxTrans));
    assign hs       = req_i && gnt_o;
    assign rvalid_o = (count_q != '0);
    assign pop      = rvalid_o && rready_i;
    assign mem_we   = hs && we_i && !addr_err;

    assign push_data = (we_i || addr_err) ? '0 : mem_q[word_idx];

    assign rdata_o = rvalid_o ? fifo_data_q[rptr_q] : '0;
    assign rid_o   = rvalid_o ? fifo_id_q[rptr_q]   : '0;
    assign err_o   = rvalid_o ? fifo_err_q[rptr_q]  : 1'b0;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        case ({hs, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (hs) begin
            wptr_d = (wptr_q == PtrW'(MaxTrans - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(MaxTrans - 1)) ? '0 : rptr_q + PtrW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // NOTE: storage arrays carry no reset; emptiness is tracked by count_q, and a reset
    // on the memory would prevent RAM inference and wipe contents that must survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (be_i[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_data_q[wptr_q] <= push_data;
            fifo_id_q[wptr_q]   <= aid_i;
            fifo_err_q[wptr_q]  <= addr_err;
        end
    end

endmodule

// File: tb/tb_obi_sbr_mem.sv
// Self-checking bench for obi_sbr_mem (default parameters); a reference word model
// feeds an in-order scoreboard that is checked whenever a response is accepted.
module tb_obi_sbr_mem;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  id;
        logic        err;
    } resp_t;

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [7:0]  aid_i;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic [7:0]  rid_o;
    logic        err_o;

    int    total = 0;
    int    bad   = 0;
    int    n_resp = 0;
    int    cyc   = 0;
    resp_t exp_q [$];
    resp_t mon_e;
    logic [31:0] model_mem [1024];

    obi_sbr_mem dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .aid_i   (aid_i),
        .rvalid_o(rvalid_o),
        .rready_i(rready_i),
        .rdata_o (rdata_o),
        .rid_o   (rid_o),
        .err_o   (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    function automatic logic range_err(input logic [31:0] a);
`ifdef OBI_SBR_MEM_RANGE_ERR_EN
        return a >= 32'h1000;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model update, called at the handshake edge.
    function automatic void push_expect(input logic [31:0] a, input logic w, input logic [3:0] b,
                                        input logic [31:0] wd, input logic [7:0] id);
        resp_t      r;
        logic [9:0] idx;
        idx    = a[11:2];
        r.id   = id;
        r.err  = range_err(a);
        r.data = '0;
        if (w) begin
            if (!r.err) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) model_mem[idx][8*k +: 8] = wd[8*k +: 8];
                end
            end
        end else if (!r.err) begin
            r.data = model_mem[idx];
        end
        exp_q.push_back(r);
    endfunction

    // Scoreboard: a response is accepted on the edge following a negedge with rvalid&rready.
    always @(negedge clk_i) begin
        if (rvalid_o && rready_i) begin
            total++;
            n_resp++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: got data=%h id=%0h err=%0b, required no response",
                         rdata_o, rid_o, err_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rdata_o, rid_o, err_o} !== {mon_e.data, mon_e.id, mon_e.err}) begin
                    bad++;
                    $display("FAIL resp: got data=%h id=%0h err=%0b, required data=%h id=%0h err=%0b",
                             rdata_o, rid_o, err_o, mon_e.data, mon_e.id, mon_e.err);
                end
            end
        end
    end

    // Drives one request and returns 1 time unit after its handshake edge.
    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd, input logic [7:0] id);
        int waited = 0;
        addr_i  = a;
        we_i    = w;
        be_i    = b;
        wdata_i = wd;
        aid_i   = id;
        req_i   = 1'b1;
        @(negedge clk_i);
        while (!gnt_o && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        if (!gnt_o) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: gnt=0 after %0d cycles, required 1", waited);
            req_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        push_expect(a, w, b, wd, id);
        #1;
    endtask

    task automatic drain();
        int waited = 0;
        req_i    = 1'b0;
        rready_i = 1'b1;
        while (exp_q.size() != 0 && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_i);
        #1;
        total++;
        if (rvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL drain_rvalid: got %b, required 0", rvalid_o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        total++;
        if ({gnt_o, rvalid_o, rdata_o, rid_o, err_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h rid=%h err=%b, required all 0",
                     gnt_o, rvalid_o, rdata_o, rid_o, err_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_gnt: got %b, required 1", gnt_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_basic();
        logic [31:0] exp_rd;
        rready_i = 1'b1;
        issue(32'h0000, 1'b1, 4'hF, 32'h5A5A0001, 8'd1);
        issue(32'h1100, 1'b1, 4'hF, 32'hDEADBEEF, 8'd2);
        drain();
        issue(32'h1100, 1'b0, 4'h0, 32'h0, 8'd3);
        exp_rd = range_err(32'h1100) ? 32'h0 : 32'hDEADBEEF;
        total++;
        if ({rvalid_o, rid_o, rdata_o} !== {1'b1, 8'd3, exp_rd}) begin
            bad++;
            $display("FAIL read_latency: got rvalid=%b rid=%0d rdata=%h, required rvalid=1 rid=3 rdata=%h",
                     rvalid_o, rid_o, rdata_o, exp_rd);
        end
        drain();
    endtask

    task automatic test_byte_enable();
        rready_i = 1'b1;
        issue(32'h20, 1'b1, 4'hF, 32'h11223344, 8'd4);
        issue(32'h20, 1'b1, 4'h2, 32'hAABBCCDD, 8'd5);
        issue(32'h20, 1'b0, 4'h0, 32'h0, 8'd6);
        total++;
        if ({rvalid_o, rid_o, rdata_o} !== {1'b1, 8'd6, 32'h1122CC44}) begin
            bad++;
            $display("FAIL byte_enable: got rvalid=%b rid=%0d rdata=%h, required 1/6/1122cc44",
                     rvalid_o, rid_o, rdata_o);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int   n = 0;
        int   resp0;
        logic g;
        resp0    = n_resp;
        rready_i = 1'b0;
        addr_i = 32'h0; we_i = 1'b0; be_i = 4'h0; wdata_i = 32'h0; aid_i = 8'h10; req_i = 1'b1;
        repeat (8) begin
            @(negedge clk_i);
            g = gnt_o;
            @(posedge clk_i);
            if (g) begin
                push_expect(addr_i, 1'b0, 4'h0, 32'h0, aid_i);
                n++;
            end
            #1;
            addr_i = n[0] ? 32'h20 : 32'h0;
            aid_i  = 8'h10 + 8'(n);
        end
        total++;
        if (n != 4 || gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL full_stall: got handshakes=%0d gnt=%b, required 4 and 0", n, gnt_o);
        end
        rready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL gnt_during_pop: got %b, required 0", gnt_o);
        end
        @(posedge clk_i);
        #1 rready_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL gnt_after_pop: got %b, required 1", gnt_o);
        end
        @(posedge clk_i);
        push_expect(addr_i, 1'b0, 4'h0, 32'h0, aid_i);
        #1;
        rready_i = 1'b1;
        issue(32'h20, 1'b0, 4'h0, 32'h0, 8'h15);
        drain();
        total++;
        if (n_resp - resp0 != 6) begin
            bad++;
            $display("FAIL backpressure_count: got %0d responses, required 6", n_resp - resp0);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int steady_bad = 0;
        rready_i = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            issue(i[0] ? 32'h20 : 32'h0, 1'b0, 4'h0, 32'h0, 8'h30 + 8'(i));
            if (rvalid_o !== 1'b1 || gnt_o !== 1'b1) steady_bad++;
        end
        total++;
        if (cyc - c0 != 8 || steady_bad != 0) begin
            bad++;
            $display("FAIL back_to_back: got cycles=%0d unsteady=%0d, required 8 and 0",
                     cyc - c0, steady_bad);
        end
        drain();
    endtask

    task automatic test_range();
        rready_i = 1'b1;
        issue(32'h0004, 1'b1, 4'hF, 32'h01020304, 8'd12);
        issue(32'h1000, 1'b0, 4'h0, 32'h0, 8'd9);
        issue(32'h1004, 1'b1, 4'hF, 32'hCAFEF00D, 8'd10);
        issue(32'h0004, 1'b0, 4'h0, 32'h0, 8'd11);
        drain();
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        rready_i = 1'b0;
        issue(32'h0, 1'b0, 4'h0, 32'h0, 8'h40);
        issue(32'h20, 1'b0, 4'h0, 32'h0, 8'h41);
        issue(32'h0, 1'b0, 4'h0, 32'h0, 8'h42);
        req_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        total++;
        if (rvalid_o !== 1'b0 || gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got rvalid=%b gnt=%b, required 0 and 0", rvalid_o, gnt_o);
        end
        exp_q.delete();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_gnt: got %b, required 1", gnt_o);
        end
        rready_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (rvalid_o !== 1'b0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL stale_resp: got %0d cycles with rvalid=1, required 0", stale);
        end
    endtask

    initial begin
        rst_i    = 1'b1;
        req_i    = 1'b0;
        addr_i   = '0;
        we_i     = 1'b0;
        be_i     = '0;
        wdata_i  = '0;
        aid_i    = '0;
        rready_i = 1'b0;
        test_reset();
        test_basic();
        test_byte_enable();
        test_backpressure();
        test_back_to_back();
        test_range();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
